// File: rtl/chip8_vga_pkg.sv
// Shared VGA 640x480@60 timing constants and CHIP-8 framebuffer geometry
// for the framebuffer scan-out block.
package chip8_vga_pkg;

  localparam int CNT_W = 10;

  localparam int H_VIS        = 640;
  localparam int H_FP         = 16;
  localparam int H_SYNC       = 96;
  localparam int H_BP         = 48;
  localparam int H_TOTAL      = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int H_SYNC_START = H_VIS + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;

  localparam int V_VIS        = 480;
  localparam int V_FP         = 10;
  localparam int V_SYNC       = 2;
  localparam int V_BP         = 33;
  localparam int V_TOTAL      = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int V_SYNC_START = V_VIS + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam int CHIP8_W = 64;
  localparam int CHIP8_H = 32;
  localparam int FB_BITS = CHIP8_W * CHIP8_H;

  // Row-major framebuffer index: y*64 + x is a plain bit concatenation.
  function automatic logic [10:0] fb_index(input logic [4:0] y, input logic [5:0] x);
    return {y, x};
  endfunction

endpackage

// File: rtl/chip8_pixel_tick.sv
// Clock-enable divider: pulses tick once every CLK_DIV system clocks.
module chip8_pixel_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q, div_d;

  always_comb begin
    div_d = (div_q == LAST) ? '0 : div_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) div_q <= '0;
    else        div_q <= div_d;
  end

  assign tick = (div_q == LAST);

endmodule

// File: rtl/chip8_vga_scan.sv
// Scans a snapshot of the 64x32 CHIP-8 framebuffer out as letterboxed
// 640x480@60 video, each CHIP-8 pixel drawn as a SCALE x SCALE block.
module chip8_vga_scan
  import chip8_vga_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int SCALE    = 10,
  parameter int V_OFFSET = 80
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FB_BITS-1:0] display,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic               pixel,
  output logic               frame_start
);

  localparam int SW = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam logic [SW-1:0] SUB_LAST = SW'(SCALE - 1);

  logic tick;

  chip8_pixel_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  logic [CNT_W-1:0]   h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [SW-1:0]      x_sub_q, x_sub_d, y_sub_q, y_sub_d;
  logic [5:0]         x_cell_q, x_cell_d;
  logic [4:0]         y_cell_q, y_cell_d;
  logic [FB_BITS-1:0] shadow_q;
  logic               hsync_q, vsync_q, de_q, pixel_q, frame_start_q;
  logic               h_last, v_last, snap, vis, band;

  always_comb begin
    h_last  = (h_cnt_q == CNT_W'(H_TOTAL - 1));
    v_last  = (v_cnt_q == CNT_W'(V_TOTAL - 1));
    h_cnt_d = h_last ? '0 : h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_last) v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;

    x_sub_d  = x_sub_q + 1'b1;
    x_cell_d = x_cell_q;
    if (h_last) begin
      x_sub_d  = '0;
      x_cell_d = '0;
    end else if (x_sub_q == SUB_LAST) begin
      x_sub_d  = '0;
      x_cell_d = x_cell_q + 1'b1;
    end

    // Vertical scaler realigns on entry to the first active line.
    y_sub_d  = y_sub_q;
    y_cell_d = y_cell_q;
    if (h_last) begin
      if (v_cnt_d == CNT_W'(V_OFFSET)) begin
        y_sub_d  = '0;
        y_cell_d = '0;
      end else if (y_sub_q == SUB_LAST) begin
        y_sub_d  = '0;
        y_cell_d = y_cell_q + 1'b1;
      end else begin
        y_sub_d  = y_sub_q + 1'b1;
      end
    end

    snap = (h_cnt_q == '0) && (v_cnt_q == CNT_W'(V_VIS));
    vis  = (h_cnt_q < CNT_W'(H_VIS)) && (v_cnt_q < CNT_W'(V_VIS));
    band = (v_cnt_q >= CNT_W'(V_OFFSET)) &&
           (v_cnt_q <  CNT_W'(V_OFFSET + CHIP8_H * SCALE));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      x_sub_q       <= '0;
      x_cell_q      <= '0;
      y_sub_q       <= '0;
      y_cell_q      <= '0;
      shadow_q      <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      de_q          <= 1'b0;
      pixel_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= tick && snap;
      if (tick) begin
        h_cnt_q  <= h_cnt_d;
        v_cnt_q  <= v_cnt_d;
        x_sub_q  <= x_sub_d;
        x_cell_q <= x_cell_d;
        y_sub_q  <= y_sub_d;
        y_cell_q <= y_cell_d;
        if (snap) shadow_q <= display;
        // Outputs lag the counters by one tick, all four together.
        hsync_q <= !((h_cnt_q >= CNT_W'(H_SYNC_START)) && (h_cnt_q < CNT_W'(H_SYNC_END)));
        vsync_q <= !((v_cnt_q >= CNT_W'(V_SYNC_START)) && (v_cnt_q < CNT_W'(V_SYNC_END)));
        de_q    <= vis;
        pixel_q <= vis && band && shadow_q[fb_index(y_cell_q, x_cell_q)];
      end
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign pixel       = pixel_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_chip8_vga_scan.sv
// Directed bench for chip8_vga_scan: one instance at CLK_DIV=4 for reset and
// sync timing, one at CLK_DIV=1 for frame, snapshot and pixel-mapping checks.
`timescale 1ns/1ps
module tb_chip8_vga_scan;
  import chip8_vga_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [FB_BITS-1:0] display = '1;
  logic h4, v4, de4, px4, fs4;
  logic h1, v1, de1, px1, fs1;
  logic [9:0] jmp_v;

  always #5 clk = ~clk;

  chip8_vga_scan #(.CLK_DIV(4)) dut4 (
    .clk(clk), .reset(reset), .display(display),
    .hsync(h4), .vsync(v4), .de(de4), .pixel(px4), .frame_start(fs4)
  );

  chip8_vga_scan #(.CLK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .display(display),
    .hsync(h1), .vsync(v1), .de(de1), .pixel(px1), .frame_start(fs1)
  );

  int n_vec = 0;
  int n_bad = 0;
  int mh = 0, mv = 0, ph = 0, pv = 0;

  typedef struct {
    int   v;
    int   h;
    logic px;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One tick of dut1; (ph,pv) is the counter state its outputs now show.
  task automatic step();
    @(posedge clk);
    ph = mh;
    pv = mv;
    if (mh == H_TOTAL - 1) begin
      mh = 0;
      mv = (mv == V_TOTAL - 1) ? 0 : mv + 1;
    end else begin
      mh = mh + 1;
    end
    #1;
  endtask

  // Park dut1 at the last pixel of line v so the next tick starts line v+1.
  task automatic jump(input int v);
    @(negedge clk);
    jmp_v = 10'(v);
    force dut1.h_cnt_q = 10'd799;
    force dut1.v_cnt_q = jmp_v;
    #1;
    release dut1.h_cnt_q;
    release dut1.v_cnt_q;
    mh = H_TOTAL - 1;
    mv = v;
  endtask

  task automatic count_line(input int v, output int ones);
    ones = 0;
    jump((v + V_TOTAL - 1) % V_TOTAL);
    repeat (H_TOTAL + 1) begin
      step();
      if (pv == v && px1) ones++;
    end
  endtask

  task automatic snapshot(input logic [FB_BITS-1:0] img, input string tag);
    jump(V_VIS - 1);
    step();
    check({tag, " fs before"}, fs1, 0);
    display = img;
    step();
    check({tag, " fs pulse"}, fs1, 1);
    step();
    check({tag, " fs width"}, fs1, 0);
  endtask

  initial begin
    logic [FB_BITS-1:0] img;
    int ones;
    int de_fall, de_rise, hs_f1, hs_f2, hs_r, vs_low;
    logic de_p, hs_p;

    // Reset values
    repeat (5) @(posedge clk);
    #1;
    check("rst hsync", h4, 1);
    check("rst vsync", v4, 1);
    check("rst de", de4, 0);
    check("rst pixel", px4, 0);
    check("rst frame_start", fs4, 0);
    check("rst de1", de1, 0);

    // First tick on the 4th edge after release
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("no tick by edge 3", de4, 0);
    @(posedge clk);
    #1;
    check("tick on edge 4", de4, 1);

    // Line timing at CLK_DIV=4
    de_fall = -1; de_rise = -1; hs_f1 = -1; hs_f2 = -1; hs_r = -1; vs_low = 0;
    de_p = de4; hs_p = h4;
    for (int k = 1; k <= 6000; k++) begin
      @(posedge clk);
      #1;
      if (de_p && !de4 && de_fall < 0) de_fall = k;
      if (!de_p && de4 && de_rise < 0) de_rise = k;
      if (hs_p && !h4) begin
        if (hs_f1 < 0) hs_f1 = k;
        else if (hs_f2 < 0) hs_f2 = k;
      end
      if (!hs_p && h4 && hs_r < 0) hs_r = k;
      if (!v4) vs_low++;
      de_p = de4;
      hs_p = h4;
    end
    check("de high clk", de_fall, 2560);
    check("de next line", de_rise, 3200);
    check("hsync fall", hs_f1, 2624);
    check("hsync low clk", hs_r - hs_f1, 384);
    check("hsync period", hs_f2 - hs_f1, 3200);
    check("vsync idle", vs_low, 0);

    // First frame after reset is blank even with display all ones
    display = '1;
    count_line(80, ones);
    check("blank first frame", ones, 0);

    // Snapshot a pattern: (0,0), (63,0), (0,1)
    img = '0;
    img[0] = 1'b1;
    img[63] = 1'b1;
    img[64] = 1'b1;
    snapshot(img, "snap1");
    display = '1;

    // Vertical sync region and frame wrap
    jump(489);
    step();
    step();
    check("vsync at 490", v1, 0);
    check("hsync at 490 h0", h1, 1);
    jump(524);
    step();
    check("de at 524/799", de1, 0);
    check("vsync at 524", v1, 1);
    step();
    check("wrap de at 0/0", de1, 1);

    // Pixel mapping; display now all ones, so these also show tear-free holds
    tbl = '{
      '{79, 0, 1'b0},   '{80, 0, 1'b1},   '{80, 9, 1'b1},   '{80, 10, 1'b0},
      '{80, 629, 1'b0}, '{80, 630, 1'b1}, '{80, 639, 1'b1}, '{80, 640, 1'b0},
      '{89, 5, 1'b1},   '{89, 635, 1'b1}, '{90, 0, 1'b1},   '{90, 630, 1'b0},
      '{99, 9, 1'b1},   '{99, 10, 1'b0},  '{100, 0, 1'b0}
    };
    ones = 0;
    jump(78);
    repeat (22 * H_TOTAL + 1) begin
      step();
      if (px1) ones++;
      foreach (tbl[i])
        if (tbl[i].v == pv && tbl[i].h == ph)
          check($sformatf("map v%0d h%0d", pv, ph), px1, tbl[i].px);
    end
    check("map lit total", ones, 300);

    // Letterbox with a fully lit snapshot
    snapshot('1, "snap2");
    count_line(0, ones);
    check("letterbox line 0", ones, 0);
    count_line(79, ones);
    check("letterbox line 79", ones, 0);
    count_line(80, ones);
    check("lit line 80", ones, 640);
    count_line(399, ones);
    check("lit line 399", ones, 640);
    count_line(400, ones);
    check("letterbox line 400", ones, 0);

    // Reset mid-frame
    jump(299);
    step();
    step();
    check("lit before reset", px1, 1);
    repeat (5) step();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid rst hsync", h1, 1);
    check("mid rst vsync", v1, 1);
    check("mid rst de", de1, 0);
    check("mid rst pixel", px1, 0);
    check("mid rst frame_start", fs1, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    mh = 0;
    mv = 0;
    step();
    check("restart de at 0/0", de1, 1);
    count_line(80, ones);
    check("blank after reset", ones, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/chip8_vga_scan.md
# chip8_vga_scan

Downstream consumer of the `chip8_top` framebuffer. It snapshots the 2048-bit `display` vector once per frame, scales each CHIP-8 pixel to 10×10 and scans the result out as 640×480@60 VGA-style timing, letterboxed as 640×320 with 80 black lines above and below. A clock-enable divider derives the pixel tick, so the whole block runs on the system clock.

## Interface
- `CLK_DIV`, default 4: system clocks per pixel tick (100 MHz → 25 MHz); legal range ≥1.
- `SCALE`, default 10: screen pixels per CHIP-8 pixel, applied both horizontally and vertically; fixed-function for 64×32.
- `V_OFFSET`, default 80: first active CHIP-8 line on screen.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous active-low reset (low = reset).
- `display`  in  2048  framebuffer; CHIP-8 pixel (x,y) = `display[y*64 + x]`, x 0..63, y 0..31.
- `hsync`  out  1  horizontal sync, active low.
- `vsync`  out  1  vertical sync, active low.
- `de`  out  1  active-video enable.
- `pixel`  out  1  pixel value; 1 = lit; always 0 when `de`=0.
- `frame_start`  out  1  one-`clk` pulse when a new snapshot is taken.

## Operation
- Divider: `div_cnt` counts 0..`CLK_DIV`-1. `tick` is asserted in the cycle where `div_cnt`=`CLK_DIV`-1. With `CLK_DIV`=1, `tick` is constantly high.
- Counters advance only on `tick`.
  - `h_cnt` runs 0..799 and wraps to 0.
  - `v_cnt` increments when `h_cnt` wraps, runs 0..524 and wraps to 0.
- Horizontal regions: visible 0..639, front porch 640..655, sync 656..751, back porch 752..799.
- Vertical regions: visible 0..479, front porch 480..489, sync 490..491, back porch 492..524.
- Scaling uses sub-counters, with no divider:
  - `x_sub`/`x_cell` reset to 0 at `h_cnt`=0. `x_sub` counts 0..9; `x_cell` increments when `x_sub` wraps.
  - `y_sub`/`y_cell` reset to 0 at the start of line `V_OFFSET`. They advance once per line in the same way.
- Snapshot:
  - On the `tick` where `h_cnt`=0 and `v_cnt`=480, the 2048-bit `shadow` register loads `display`.
  - `frame_start` pulses in that same `clk` cycle.
  - Changes to `display` at any other time have no visible effect until the next snapshot, so output is tear-free.
- Output rules:
  - `de` = (`h_cnt`<640) and (`v_cnt`<480).
  - `pixel` = `de` and (`V_OFFSET` ≤ `v_cnt` < `V_OFFSET`+320) and `shadow[y_cell*64 + x_cell]`.
- Reset values: `div_cnt`, `h_cnt`, `v_cnt`, all sub-counters and `shadow` = 0; `hsync`=1, `vsync`=1, `de`=0, `pixel`=0, `frame_start`=0.
- Reset asserted mid-frame: all state returns to the reset values immediately. The first frame after reset shows a blank `shadow` until the first snapshot.

## Timing
- `hsync`, `vsync`, `de` and `pixel` are registered and updated on `tick`. All four reflect the counter state of the previous tick: one pixel-tick latency, identical for each, so they stay mutually aligned.
- Outputs hold their value between ticks.
- `frame_start` is registered and one `clk` wide regardless of `CLK_DIV`. It is asserted in the cycle after the snapshot tick edge, and `shadow` is valid in that same cycle.
- Line = 800 ticks = 800·`CLK_DIV` clk. Frame = 525 lines = 420 000 ticks (1 680 000 clk at `CLK_DIV`=4).
- First `tick` after reset release occurs on the `CLK_DIV`-th rising edge.

## Structure
- Package `chip8_vga_pkg`: H/V visible, porch and sync constants; `CHIP8_W`=64, `CHIP8_H`=32; `FB_BITS`=2048.
- Sub-module `chip8_pixel_tick`: parameterised clock-enable divider (`clk`, `reset`, `tick`).
- The top file holds the counters, scaler, shadow register and output registers; target 150–250 lines.

## Test plan
- Reset: hold `reset`=0 for 5 clk → `hsync`=1, `vsync`=1, `de`=0, `pixel`=0, `frame_start`=0; after release, first `tick` on the 4th edge.
- Sync timing (`CLK_DIV`=4):
  - `hsync` low for exactly 96 ticks (384 clk), period 3200 clk.
  - `vsync` low for 2 lines, period 1 680 000 clk.
  - `de` high 640 ticks per visible line.
- Mapping:
  - `display[0]`=1 only → `pixel`=1 for `h_cnt` 0..9 on `v_cnt` 80..89, else 0.
  - `display[2047]`=1 only → `pixel`=1 for `h_cnt` 630..639 on `v_cnt` 390..399.
- Letterbox: `display` all ones → `pixel`=0 on lines 0..79 and 400..479, 1 across all of lines 80..399.
- Tear-free: toggle `display` from all zeros to all ones at `v_cnt`=200 → `pixel` stays 0 for the rest of that frame; `frame_start` pulses once at `v_cnt`=480; the next frame is all lit.
- Wrap/reset: at `h_cnt`=799, `v_cnt`=524, the next tick gives `h_cnt`=0, `v_cnt`=0. Drop `reset` at `v_cnt`=300 → outputs return to reset values immediately and the scan restarts from 0,0 with a blank frame.
